// File: rtl/ir_frame_tx.sv
// ir_frame_tx: pulse-distance IR frame transmitter (leader, LSB-first payload, stop mark) on a modulated carrier.
// Optional even-parity bit after the MSB when IR_FRAME_TX_PARITY_EN is defined.
module ir_frame_tx #(
  parameter int DATA_W      = 11,
  parameter int UNIT_CYCLES = 56250,
  parameter int CARRIER_DIV = 2632,
  parameter int LEAD_MARK   = 16,
  parameter int LEAD_SPACE  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              emitter
);
`ifdef IR_FRAME_TX_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif
  localparam int LMAX = LEAD_MARK > LEAD_SPACE ? LEAD_MARK : LEAD_SPACE;
  localparam int MAXL = LMAX > 3 ? LMAX : 3;
  localparam int UW = $clog2(UNIT_CYCLES);
  localparam int CW = $clog2(CARRIER_DIV);
  localparam int LW = $clog2(MAXL);
  localparam int BW = $clog2(NB + 1);

  typedef enum logic [2:0] {IDLE, LEAD_M, LEAD_S, BIT_M, BIT_S, STOP_M, DONE} state_t;

  state_t          state_q, state_d;
  logic [UW-1:0]   unit_cnt_q, unit_cnt_d;
  logic [LW-1:0]   len_cnt_q, len_cnt_d, len_m1;
  logic [CW-1:0]   carr_q, carr_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB-1:0]   sreg_q, sreg_d, sreg_load;
  logic            busy_q, busy_d, done_q, done_d, emitter_q, emitter_d;
  logic            unit_last, st_end, accept, mark_d, bit_end;

  assign busy    = busy_q;
  assign done    = done_q;
  assign emitter = emitter_q;

`ifdef IR_FRAME_TX_PARITY_EN
  assign sreg_load = {^data, data};
`else
  assign sreg_load = data;
`endif

  assign unit_last = unit_cnt_q == UW'(UNIT_CYCLES - 1);
  assign st_end    = unit_last && len_cnt_q == len_m1;
  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign bit_end   = state_q == BIT_S && st_end;
  assign mark_d    = state_d inside {LEAD_M, BIT_M, STOP_M};

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      unit_cnt_q <= '0;
      len_cnt_q  <= '0;
      carr_q     <= '0;
      bit_cnt_q  <= '0;
      sreg_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      emitter_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_cnt_q <= unit_cnt_d;
      len_cnt_q  <= len_cnt_d;
      carr_q     <= carr_d;
      bit_cnt_q  <= bit_cnt_d;
      sreg_q     <= sreg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      emitter_q  <= emitter_d;
    end
  end

  // Next state: each timed state ends on the last cycle of its last unit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LEAD_M : IDLE;
      LEAD_M:  state_d = st_end ? LEAD_S : LEAD_M;
      LEAD_S:  state_d = st_end ? BIT_M : LEAD_S;
      BIT_M:   state_d = st_end ? BIT_S : BIT_M;
      BIT_S:   state_d = st_end ? (bit_cnt_q == BW'(NB - 1) ? STOP_M : BIT_M) : BIT_S;
      STOP_M:  state_d = st_end ? DONE : STOP_M;
      DONE:    state_d = start ? LEAD_M : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters and shift register; unit length of the current state (minus one)
  always_comb begin
    len_m1     = state_q == LEAD_M ? LW'(LEAD_MARK - 1) :
                 state_q == LEAD_S ? LW'(LEAD_SPACE - 1) :
                 (state_q == BIT_S && sreg_q[0]) ? LW'(2) : '0;
    unit_cnt_d = (busy_q && !unit_last) ? unit_cnt_q + 1'b1 : '0;
    len_cnt_d  = state_d != state_q ? '0 : unit_last ? len_cnt_q + 1'b1 : len_cnt_q;
    carr_d     = (mark_d && state_d == state_q && carr_q != CW'(CARRIER_DIV - 1)) ? carr_q + 1'b1 : '0;
    bit_cnt_d  = accept ? '0 : bit_end ? bit_cnt_q + 1'b1 : bit_cnt_q;
    sreg_d     = accept ? sreg_load : bit_end ? sreg_q >> 1 : sreg_q;
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    busy_d    = state_d inside {LEAD_M, LEAD_S, BIT_M, BIT_S, STOP_M};
    done_d    = state_d == DONE;
    emitter_d = mark_d && carr_d < CW'(CARRIER_DIV / 2);
  end
endmodule

// File: tb/tb_ir_frame_tx.sv
// tb_ir_frame_tx: randomized self-checking bench against a segment-level waveform model.
module tb_ir_frame_tx;
  localparam int DW = 4, U = 4, CD = 2, LM = 2, LS = 1;

  logic clk = 0, rst = 1, start = 0;
  logic [DW-1:0] data = '0;
  logic busy, done, emitter;
  int errors = 0, checks = 0;
  bit exp_q[$];

  ir_frame_tx #(.DATA_W(DW), .UNIT_CYCLES(U), .CARRIER_DIV(CD), .LEAD_MARK(LM), .LEAD_SPACE(LS)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .busy(busy), .done(done), .emitter(emitter));

  always #5 clk = ~clk;

  function automatic void add_seg(input int units, input bit mark);
    for (int c = 0; c < units * U; c++) exp_q.push_back(mark && (c % CD) < CD / 2);
  endfunction

  function automatic void build(input logic [DW-1:0] d);
    bit bits[$];
    exp_q = {};
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef IR_FRAME_TX_PARITY_EN
    bits.push_back(^d);
`endif
    add_seg(LM, 1);
    add_seg(LS, 0);
    foreach (bits[i]) begin
      add_seg(1, 1);
      add_seg(bits[i] ? 3 : 1, 0);
    end
    add_seg(1, 1);
  endfunction

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, emitter} !== 3'b000) begin
        errors++;
        $display("FAIL idle cyc%0d: busy/done/emitter=%b want 000", k, {busy, done, emitter});
      end
    end
  endtask

  task automatic test_frame(input logic [DW-1:0] d, input int pulse_at);
    build(d);
    @(negedge clk);
    start = 1;
    data = d;
    foreach (exp_q[k]) begin
      @(negedge clk);
      start = (k == pulse_at);
      data = DW'($urandom);
      checks++;
      if ({busy, emitter, done} !== {1'b1, exp_q[k], 1'b0}) begin
        errors++;
        $display("FAIL frame d=%b cyc%0d: busy/emitter/done=%b want %b", d, k, {busy, emitter, done}, {1'b1, exp_q[k], 1'b0});
      end
    end
    @(negedge clk);
    start = 0;
    checks++;
    if ({busy, emitter, done} !== 3'b001) begin
      errors++;
      $display("FAIL frame_done d=%b: busy/emitter/done=%b want 001", d, {busy, emitter, done});
    end
    @(negedge clk);
    checks++;
    if ({busy, emitter, done} !== 3'b000) begin
      errors++;
      $display("FAIL frame_after d=%b: busy/emitter/done=%b want 000", d, {busy, emitter, done});
    end
  endtask

  task automatic test_reset_mid(input logic [DW-1:0] d);
    build(d);
    @(negedge clk);
    start = 1;
    data = d;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if ({busy, emitter} !== {1'b1, exp_q[k]}) begin
        errors++;
        $display("FAIL pre_rst cyc%0d: busy/emitter=%b want %b", k, {busy, emitter}, {1'b1, exp_q[k]});
      end
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 70; k++) begin
      checks++;
      if ({busy, emitter, done} !== 3'b000) begin
        errors++;
        $display("FAIL post_rst cyc%0d: busy/emitter/done=%b want 000", k, {busy, emitter, done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_start();
    @(negedge clk);
    rst = 1;
    start = 1;
    data = DW'($urandom);
    @(negedge clk);
    rst = 0;
    start = 0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({busy, emitter, done} !== 3'b000) begin
        errors++;
        $display("FAIL rst_start cyc%0d: busy/emitter/done=%b want 000", k, {busy, emitter, done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back(input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    build(d1);
    @(negedge clk);
    start = 1;
    data = d1;
    foreach (exp_q[k]) begin
      @(negedge clk);
      data = d2;
      checks++;
      if ({busy, emitter, done} !== {1'b1, exp_q[k], 1'b0}) begin
        errors++;
        $display("FAIL b2b_first cyc%0d: busy/emitter/done=%b want %b", k, {busy, emitter, done}, {1'b1, exp_q[k], 1'b0});
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done: busy/done=%b want 01", {busy, done});
    end
    build(d2);
    foreach (exp_q[k]) begin
      @(negedge clk);
      start = 0;
      data = DW'($urandom);
      checks++;
      if ({busy, emitter, done} !== {1'b1, exp_q[k], 1'b0}) begin
        errors++;
        $display("FAIL b2b_second cyc%0d: busy/emitter/done=%b want %b", k, {busy, emitter, done}, {1'b1, exp_q[k], 1'b0});
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, emitter, done} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_second_done: busy/emitter/done=%b want 001", {busy, emitter, done});
    end
  endtask

  initial begin
    test_reset();
    test_frame(4'b0101, -1);
    test_frame(4'b0000, -1);
    test_frame(4'b1111, -1);
    for (int i = 0; i < 6; i++) test_frame(DW'($urandom), -1);
    test_frame(4'b0101, 10);
    test_frame(DW'($urandom), $urandom_range(0, 40));
    test_reset_mid(4'b0101);
    test_rst_start();
    test_back_to_back(4'b0101, 4'b1010);
    test_back_to_back(DW'($urandom), DW'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ir_frame_tx.md
IR_FRAME_TX -- requirements
Module: ir_frame_tx

Interface
REQ-001 Parameter DATA_W, default 11: payload width in bits, range 1..32.
REQ-002 Parameter UNIT_CYCLES, default 56250: clk cycles per timing unit (562.5 us at 100 MHz), minimum 2.
REQ-003 Parameter CARRIER_DIV, default 2632: carrier period in clk cycles (about 38 kHz), minimum 2.
REQ-004 Parameter LEAD_MARK, default 16: leader mark length in units.
REQ-005 Parameter LEAD_SPACE, default 8: leader space length in units.
REQ-006 Port clk, input, 1: the single clock for the whole block.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: one-cycle request, already synchronized and debounced upstream.
REQ-009 Port data, input, DATA_W: payload, sampled on the accepted start cycle.
REQ-010 Port busy, output, 1: high while a frame is in progress.
REQ-011 Port done, output, 1: one-cycle pulse at frame completion.
REQ-012 Port emitter, output, 1: modulated IR LED drive.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, LEAD_M, LEAD_S, BIT_M, BIT_S, STOP_M and DONE.
REQ-014 In IDLE, start=1 SHALL latch data into a shift register, and the FSM SHALL enter LEAD_M on the next clock; busy and emitter SHALL be registered, so both are first high one cycle after start.
REQ-015 The FSM SHALL spend exactly LEAD_MARK units in LEAD_M and exactly LEAD_SPACE units in LEAD_S.
REQ-016 Payload bits SHALL be sent LSB first, each as BIT_M for 1 unit followed by BIT_S for 1 unit (bit=0) or 3 units (bit=1).
REQ-017 After the last bit, the FSM SHALL spend 1 unit in STOP_M, then 1 cycle in DONE with done=1 and busy=0, then return to IDLE.
REQ-018 During mark states, emitter SHALL equal the carrier; during all other states, emitter SHALL be 0.
REQ-019 Carrier: the carrier counter SHALL restart at 0 on entry to every mark state; emitter=1 while count < CARRIER_DIV/2 (floor), otherwise 0; the counter SHALL wrap to 0 at CARRIER_DIV-1.
REQ-020 The unit counter SHALL count 0..UNIT_CYCLES-1 and wrap; the unit count within each state SHALL be tracked by a separate counter sized for the largest of LEAD_MARK, LEAD_SPACE and 3.
REQ-021 Counter widths SHALL be derived with $clog2 from the parameters; no counter may overflow at any legal parameter value.
REQ-022 start SHALL be ignored while busy=1; data changes during a frame SHALL NOT affect the frame in progress.
REQ-023 start=1 in the DONE cycle SHALL be accepted, so back-to-back frames have no gap beyond the DONE cycle.
REQ-024 Total frame length SHALL be (LEAD_MARK+LEAD_SPACE+2*N0+4*N1+1)*UNIT_CYCLES cycles of busy=1, where N0 and N1 are the counts of 0 and 1 bits in the frame.

Reset
REQ-025 On rst=1 at a clock edge: FSM to IDLE; busy=0, done=0, emitter=0; all counters and the shift register to 0.
REQ-026 A reset mid-frame SHALL abort the frame with emitter=0 from the next cycle, with no done pulse.
REQ-027 If rst and start are both 1 in the same cycle, rst SHALL win.

Configuration
REQ-028 Macro IR_FRAME_TX_PARITY_EN defined: an even-parity bit over data SHALL be sent after the MSB, encoded as in REQ-016 and counted in REQ-024.
REQ-029 Macro IR_FRAME_TX_PARITY_EN undefined: no parity bit SHALL be sent and no parity logic SHALL exist.

Verification (DATA_W=4, UNIT_CYCLES=4, CARRIER_DIV=2, LEAD_MARK=2, LEAD_SPACE=1)
REQ-030 Reset then idle 20 cycles -> busy=0, done=0 and emitter=0 throughout.
REQ-031 start pulse with data=4'b0101, parity off -> busy high 64 cycles; emitter toggles 1,0 every cycle for the first 8 cycles then is 0 for 4; done high exactly once, at the cycle after busy falls.
REQ-032 Same stimulus with IR_FRAME_TX_PARITY_EN defined (parity=0) -> busy high 72 cycles.
REQ-033 Second start pulse at cycle 10 of a frame -> ignored: same 64-cycle frame and a single done pulse.
REQ-034 rst asserted at cycle 30 of a frame -> emitter=0 and busy=0 from the next cycle, and no done pulse.
REQ-035 start held high through the DONE cycle -> second frame begins immediately, busy high again the cycle after DONE, with new data captured.
